// File: rtl/fa_serial_adder.sv
// Bit-serial LSB-first adder built around a single decoder-based full adder cell.
// Optional subtract mode is enabled by defining FA_SERIAL_SUB_EN.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic [7:0] dec;

  // One-hot minterm decode of {a,b,cin}; sum/cout are ORs of selected minterms.
  assign dec  = 8'b1 << {a, b, cin};
  assign sum  = |(dec & 8'b1001_0110);
  assign cout = |(dec & 8'b1110_1000);
endmodule

module fa_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef FA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co, load;
  logic [WIDTH:0]   res_sh;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  fa u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign load   = ready && start;
  // Sum bit enters at the MSB; the concatenation keeps the shift legal for WIDTH=1.
  assign res_sh = {fa_s, res_q};

`ifdef FA_SERIAL_SUB_EN
  assign b_ld = sub ? ~b_in : b_in;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b_in;
  assign c_ld = cin;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        res_d   = res_sh[WIDTH:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_sh[WIDTH:1];
          cout_d  = fa_co;
        end
      end
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      sa_d    = a_in;
      sb_d    = b_ld;
      carry_d = c_ld;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_fa_serial_adder.sv
// Scoreboard bench for fa_serial_adder: stimulus pushes expected results, a monitor checks done pulses.
module tb_fa_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         cin = 1'b0;
`ifdef FA_SERIAL_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    longint       due;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     n_chk = 0, n_err = 0;

  fa_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef FA_SERIAL_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding result, on time.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      n_chk++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (sum !== e.s || cout !== e.c || cyc != e.due || ready !== 1'b1) begin
          n_err++;
          $display("FAIL result: got sum=%0h cout=%0b cyc=%0d ready=%0b expected sum=%0h cout=%0b cyc=%0d ready=1",
                   sum, cout, cyc, ready, e.s, e.c, e.due);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, b, input logic c, s, input longint due);
    exp_t        e;
    logic [W:0]  t;
    longint unsigned bv, cv;
    bv = s ? ((1 << W) - 1 - longint'(b)) : longint'(b);
    cv = s ? 1 : longint'(c);
    t  = W'(0) + (longint'(a) + bv + cv);
    e.s   = t[W-1:0];
    e.c   = t[W];
    e.due = due;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, b, input logic c, s, input bit push);
    int t = 0;
    while (ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (ready !== 1'b1) begin
      n_chk++; n_err++;
      $display("FAIL ready_timeout: got ready=%0b expected 1", ready);
      return;
    end
    a_in = a; b_in = b; cin = c; start = 1'b1;
`ifdef FA_SERIAL_SUB_EN
    sub = s;
`endif
    @(posedge clk); #1;
    if (push) q.push_back(model(a, b, c, s, cyc + W));
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
`ifdef FA_SERIAL_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain_pending", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    longint c0;
    repeat (2) @(negedge clk);
    chk("reset_state", {sum, cout, done, ready, busy}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    drain();
    chk("hold_sum", {sum, cout}, {8'h96, 1'b0});
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    drain();

    // start mid-SHIFT must be ignored
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("busy_mid", {busy, ready}, {1'b1, 1'b0});
    a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // start held high: three back-to-back operations
    @(negedge clk);
    a_in = 8'h01; b_in = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) q.push_back(model(8'h01, 8'h02, 1'b0, 1'b0, c0 + k * (W + 1) + W));
    while (cyc < c0 + 2 * (W + 1)) @(posedge clk);
    #1 start = 1'b0;
    drain();

    // reset during the 4th SHIFT cycle abandons the operation
    issue(8'h77, 8'h66, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("mid_reset", {sum, cout, done, ready, busy}, {8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    issue(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    drain();

`ifdef FA_SERIAL_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
    issue(8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
    drain();
`endif

    for (int i = 0; i < 40; i++) begin
      logic s;
      s = 1'b0;
`ifdef FA_SERIAL_SUB_EN
      s = 1'($urandom);
`endif
      issue(W'($urandom), W'($urandom), 1'($urandom), s, 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
